// File: rtl/vctrl_pkg.sv
// Shared types for the vector control sequencer: opcode encoding, the
// registered Execute-stage control word, sequencer states and the
// vector-class membership helper.
package vctrl_pkg;

  localparam int OPC_W = 4;
  localparam int ALU_W = 3;

  // ALU operation encodings used by the decoder.
  localparam logic [ALU_W-1:0] ALU_ADD  = 3'b000;
  localparam logic [ALU_W-1:0] ALU_SUB  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_VSC  = 3'b010;
  localparam logic [ALU_W-1:0] ALU_VOP3 = 3'b011;
  localparam logic [ALU_W-1:0] ALU_MEM  = 3'b110;
  localparam logic [ALU_W-1:0] ALU_PASS = 3'b111;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP      = 4'b0000,
    OP_VSTORE   = 4'b0001,
    OP_VLOAD    = 4'b0010,
    OP_MOVI     = 4'b0011,
    OP_OUT      = 4'b0100,
    OP_ADD      = 4'b0101,
    OP_SUB      = 4'b0110,
    OP_VADD     = 4'b0111,
    OP_VSUB     = 4'b1000,
    OP_VALU3    = 4'b1001,
    OP_VSCALAR  = 4'b1010,
    OP_CMP      = 4'b1011,
    OP_BRANCH0  = 4'b1100,
    OP_BRANCH1  = 4'b1101,
    OP_BRANCH2  = 4'b1110,
    OP_ILLEGAL  = 4'b1111
  } opcode_e;

  // Execute-stage control word; field order mirrors the output port list.
  typedef struct packed {
    logic             use_scalar_alu;
    logic             is_scalar_output;
    logic             is_scalar_reg1;
    logic             is_scalar_reg2;
    logic             result_selector_wb;
    logic             write_enable_scalar_wb;
    logic             write_enable_vector_wb;
    logic             write_to_memory_enable_m;
    logic             use_inmediate;
    logic             out_flag_m;
    logic [ALU_W-1:0] alu_control;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // IDLE: nothing live in E. SINGLE: one-beat instruction or the last beat
  // of a vector instruction. MULTI: a vector beat that is not the last.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SINGLE = 2'd1,
    ST_MULTI  = 2'd2
  } state_e;

  // Vector-class instructions are issued as one beat per lane group.
  function automatic logic VECTOR_CLASS(opcode_e op);
    return op inside {OP_VSTORE, OP_VLOAD, OP_VADD, OP_VSUB, OP_VALU3, OP_VSCALAR};
  endfunction

endpackage

// File: rtl/vctrl_decode.sv
// Pure combinational opcode decoder: opcode -> Execute control word plus
// the vector-class flag. Undecoded opcodes (NOP, 1111) produce all-zero control.
module vctrl_decode
  import vctrl_pkg::*;
(
  input  opcode_e opcode,
  output ctrl_t   ctrl,
  output logic    is_vector
);

  // Decode table; every field starts at zero and each opcode sets only its bits.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    ctrl      = CTRL_NOP;
    is_vector = VECTOR_CLASS(opcode);
    case (opcode)
      OP_VSTORE: begin
        ctrl.use_scalar_alu           = 1'b1;
        ctrl.is_scalar_reg1           = 1'b1;
        ctrl.write_to_memory_enable_m = 1'b1;
        ctrl.alu_control              = ALU_MEM;
      end
      OP_VLOAD: begin
        ctrl.use_scalar_alu         = 1'b1;
        ctrl.is_scalar_reg1         = 1'b1;
        ctrl.result_selector_wb     = 1'b1;
        ctrl.write_enable_vector_wb = 1'b1;
        ctrl.alu_control            = ALU_MEM;
      end
      OP_MOVI: begin
        ctrl.use_scalar_alu         = 1'b1;
        ctrl.is_scalar_output       = 1'b1;
        ctrl.write_enable_scalar_wb = 1'b1;
        ctrl.use_inmediate          = 1'b1;
        ctrl.alu_control            = ALU_PASS;
      end
      OP_OUT: begin
        ctrl.use_scalar_alu     = 1'b1;
        ctrl.is_scalar_reg1     = 1'b1;
        ctrl.result_selector_wb = 1'b1;
        ctrl.out_flag_m         = 1'b1;
        ctrl.alu_control        = ALU_MEM;
      end
      OP_ADD, OP_SUB: begin
        ctrl.use_scalar_alu         = 1'b1;
        ctrl.is_scalar_output       = 1'b1;
        ctrl.is_scalar_reg1         = 1'b1;
        ctrl.is_scalar_reg2         = 1'b1;
        ctrl.write_enable_scalar_wb = 1'b1;
        ctrl.alu_control            = (opcode == OP_ADD) ? ALU_ADD : ALU_SUB;
      end
      OP_VADD: begin
        ctrl.write_enable_vector_wb = 1'b1;
        ctrl.alu_control            = ALU_ADD;
      end
      OP_VSUB: begin
        ctrl.write_enable_vector_wb = 1'b1;
        ctrl.alu_control            = ALU_SUB;
      end
      OP_VALU3: begin
        ctrl.write_enable_vector_wb = 1'b1;
        ctrl.alu_control            = ALU_VOP3;
      end
      OP_VSCALAR: begin
        ctrl.is_scalar_reg2         = 1'b1;
        ctrl.write_enable_vector_wb = 1'b1;
        ctrl.alu_control            = ALU_VSC;
      end
      OP_CMP: begin
        ctrl.use_scalar_alu   = 1'b1;
        ctrl.is_scalar_output = 1'b1;
        ctrl.is_scalar_reg1   = 1'b1;
        ctrl.is_scalar_reg2   = 1'b1;
        ctrl.alu_control      = ALU_SUB;
      end
      OP_BRANCH0, OP_BRANCH1, OP_BRANCH2: begin
        ctrl.use_scalar_alu = 1'b1;
        ctrl.use_inmediate  = 1'b1;
        ctrl.alu_control    = ALU_PASS;
      end
      default: ctrl = CTRL_NOP; // NOP and the illegal opcode
    endcase
  end

endmodule

// File: rtl/vector_control_sequencer.sv
// Registered Decode->Execute control sequencer for the vector pipeline.
// Scalar instructions occupy E for one beat; vector-class instructions are
// issued as VECTOR_LENGTH/LANES lane-group beats with the control word held.
// Handshake: readyD (combinational), stallE freezes all state, flushE drops
// the live instruction. Optional macro VCTRL_ILLEGAL_TRAP_EN adds the
// illegalOpE output, raised for the single beat of an accepted 1111 opcode.
module vector_control_sequencer
  import vctrl_pkg::*;
#(
  parameter  int OPCODE_WIDTH   = 4,
  parameter  int VECTOR_LENGTH  = 8,
  parameter  int LANES          = 4,
  parameter  int ALU_CTRL_WIDTH = 3,
  localparam int BEATS          = VECTOR_LENGTH / LANES,
  localparam int BEAT_WIDTH     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [OPCODE_WIDTH-1:0]   opcodeD,
  input  logic                      validD,
  output logic                      readyD,
  input  logic                      stallE,
  input  logic                      flushE,
  output logic                      validE,
  output logic                      useScalarAluE,
  output logic                      isScalarOutputE,
  output logic                      isScalarReg1E,
  output logic                      isScalarReg2E,
  output logic                      resultSelectorWBE,
  output logic                      writeEnableScalarWBE,
  output logic                      writeEnableVectorWBE,
  output logic                      writeToMemoryEnableME,
  output logic                      useInmediateE,
  output logic                      outFlagME,
  output logic [ALU_CTRL_WIDTH-1:0] aluControlE,
  output logic [BEAT_WIDTH-1:0]     beatE,
  output logic                      firstBeatE,
  output logic                      lastBeatE
`ifdef VCTRL_ILLEGAL_TRAP_EN
  ,
  output logic                      illegalOpE
`endif
);

  // Configurations the sequencer cannot support are rejected at elaboration.
  if (OPCODE_WIDTH != OPC_W) begin : g_bad_opcode_width
    $error("vector_control_sequencer: OPCODE_WIDTH must be 4");
  end
  if (ALU_CTRL_WIDTH != ALU_W) begin : g_bad_alu_width
    $error("vector_control_sequencer: ALU_CTRL_WIDTH must be 3");
  end
  if (LANES < 1 || VECTOR_LENGTH < LANES || (VECTOR_LENGTH % LANES) != 0) begin : g_bad_lanes
    $error("vector_control_sequencer: VECTOR_LENGTH must be a non-zero multiple of LANES");
  end

  localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'(BEATS - 1);

  state_e                state_q, state_d;
  logic [BEAT_WIDTH-1:0] beat_q, beat_d;
  logic [BEAT_WIDTH-1:0] beat_inc;
  ctrl_t                 ctrl_q, ctrl_d;
  ctrl_t                 dec_ctrl;
  logic                  dec_vector;
  opcode_e               op_d;
  logic                  adv;
  logic                  accept;
`ifdef VCTRL_ILLEGAL_TRAP_EN
  logic                  illegal_q, illegal_d;
`endif

  assign op_d = opcode_e'(opcodeD);

  vctrl_decode u_decode (
    .opcode    (op_d),
    .ctrl      (dec_ctrl),
    .is_vector (dec_vector)
  );

  // A new instruction may enter only when E is empty or showing its last
  // beat, and never while E is stalled, flushed or in reset.
  assign adv    = !stallE;
  assign readyD = !reset && !flushE && adv && (state_q != ST_MULTI);
  assign accept = validD && readyD;

  // Next-state logic: flush first, then accept, then beat stepping, else drain to idle.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    ctrl_d   = ctrl_q;
    beat_inc = beat_q + 1'b1;
`ifdef VCTRL_ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    if (flushE) begin
      state_d = ST_IDLE;
      beat_d  = '0;
      ctrl_d  = CTRL_NOP;
`ifdef VCTRL_ILLEGAL_TRAP_EN
      illegal_d = 1'b0;
`endif
    end else if (adv) begin
      if (accept) begin
        ctrl_d  = dec_ctrl;
        beat_d  = '0;
        state_d = (dec_vector && (BEATS > 1)) ? ST_MULTI : ST_SINGLE;
`ifdef VCTRL_ILLEGAL_TRAP_EN
        illegal_d = (op_d == OP_ILLEGAL);
`endif
      end else if (state_q == ST_MULTI) begin
        // Control word stays put; only the lane-group index moves.
        beat_d  = beat_inc;
        state_d = (beat_inc == LAST_BEAT) ? ST_SINGLE : ST_MULTI;
      end else begin
        state_d = ST_IDLE;
        beat_d  = '0;
        ctrl_d  = CTRL_NOP;
`ifdef VCTRL_ILLEGAL_TRAP_EN
        illegal_d = 1'b0;
`endif
      end
    end
  end

  // State register with synchronous reset; a stall holds every flop via the _d defaults.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      ctrl_q  <= CTRL_NOP;
`ifdef VCTRL_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      ctrl_q  <= ctrl_d;
`ifdef VCTRL_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  // Control is zeroed whenever E is idle, so write enables are already gated.
  assign validE                = (state_q != ST_IDLE);
  assign useScalarAluE         = ctrl_q.use_scalar_alu;
  assign isScalarOutputE       = ctrl_q.is_scalar_output;
  assign isScalarReg1E         = ctrl_q.is_scalar_reg1;
  assign isScalarReg2E         = ctrl_q.is_scalar_reg2;
  assign resultSelectorWBE     = ctrl_q.result_selector_wb;
  assign writeEnableScalarWBE  = ctrl_q.write_enable_scalar_wb;
  assign writeEnableVectorWBE  = ctrl_q.write_enable_vector_wb;
  assign writeToMemoryEnableME = ctrl_q.write_to_memory_enable_m;
  assign useInmediateE         = ctrl_q.use_inmediate;
  assign outFlagME             = ctrl_q.out_flag_m;
  assign aluControlE           = ctrl_q.alu_control;
  assign beatE                 = beat_q;
  assign firstBeatE            = validE && (beat_q == '0);
  // SINGLE covers both one-beat instructions and the final vector beat.
  assign lastBeatE             = (state_q == ST_SINGLE);
`ifdef VCTRL_ILLEGAL_TRAP_EN
  assign illegalOpE            = illegal_q;
`endif

endmodule
